// File: rtl/rf_bank_arbiter.sv
// rf_bank_arbiter: arbitrates the single read/write port of one register-file
// bank between NUM_OC operand-collector readers and the CDB writeback path.
// Writes normally win. After MAX_STARVE back-to-back writes while a read is
// waiting, one read is forced through. Reads rotate round-robin across the
// collectors, and each read comes back tagged with its collector ID.
//
// Handshake: a request is taken in the cycle where its valid and its
// combinational ready are both high. Ready never depends on anything except
// the current inputs and the registered state. A requester must hold valid,
// row and data stable until it sees ready. Nothing is latched before ready.
module rf_bank_arbiter #(
  parameter int NUM_OC     = 4,
  parameter int OCID_W     = 2,
  parameter int ROW_W      = 3,
  parameter int DATA_W     = 256,
  parameter int MAX_STARVE = 4,
  parameter int RF_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OC-1:0]       oc_req_valid,
  input  logic [NUM_OC*ROW_W-1:0] oc_req_row,
  output logic [NUM_OC-1:0]       oc_req_ready,
  input  logic                    wb_valid,
  input  logic [ROW_W-1:0]        wb_row,
  input  logic [DATA_W-1:0]       wb_data,
  output logic                    wb_ready,
  output logic                    rf_en,
  output logic                    rf_wr,
  output logic [ROW_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]       rf_wdata,
  input  logic [DATA_W-1:0]       rf_rdata,
  output logic                    rd_valid,
  output logic [OCID_W-1:0]       rd_ocid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    starve_force
);

  typedef enum logic {WR_PRIO = 1'b0, RD_FORCE = 1'b1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_STARVE);

  state_t              state, state_nxt;
  logic [OCID_W-1:0]   rr_ptr;
  logic [3:0]          starve_cnt, starve_cnt_nxt;
  logic                any_rd;
  logic [OCID_W-1:0]   sel;
  logic [ROW_W-1:0]    sel_row;
  logic                gnt_rd, gnt_wr;
  logic [RF_LAT:0]              tag_v;
  logic [RF_LAT:0][OCID_W-1:0]  tag_id;

  // Round-robin pick: first valid collector at or after rr_ptr, with wrap-around.
  always_comb begin
    int idx;
    logic found;
    found  = 1'b0;
    sel    = rr_ptr;
    idx    = 0;
    any_rd = |oc_req_valid;
    for (int k = 0; k < NUM_OC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_OC;
      if (!found && oc_req_valid[idx]) begin
        found = 1'b1;
        sel   = OCID_W'(idx);
      end
    end
    sel_row = oc_req_row[int'(sel)*ROW_W +: ROW_W];
  end

  // Grant decision, next state and starvation count.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    gnt_rd         = 1'b0;
    gnt_wr         = 1'b0;
    case (state)
      RD_FORCE: begin
        starve_cnt_nxt = '0;
        if (any_rd) begin
          // Same-row write goes first so the forced read sees the new data.
          if (wb_valid && (sel_row == wb_row)) begin
            gnt_wr = 1'b1;
          end else begin
            gnt_rd    = 1'b1;
            state_nxt = WR_PRIO;
          end
        end else begin
          state_nxt = WR_PRIO;
          gnt_wr    = wb_valid;
        end
      end
      default: begin
        if (wb_valid) begin
          gnt_wr = 1'b1;
          if (any_rd) begin
            if (starve_cnt + 4'd1 == MAX_CNT) begin
              state_nxt      = RD_FORCE;
              starve_cnt_nxt = '0;
            end else begin
              starve_cnt_nxt = starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt_nxt = '0;
          end
        end else begin
          gnt_rd         = any_rd;
          starve_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Grant outputs. These are held low while reset is asserted.
  always_comb begin
    oc_req_ready = '0;
    if (gnt_rd && !rst) oc_req_ready[sel] = 1'b1;
    wb_ready     = gnt_wr && !rst;
    starve_force = (state == RD_FORCE);
    rd_valid     = tag_v[RF_LAT];
    rd_ocid      = tag_id[RF_LAT];
    rd_data      = rf_rdata;
  end

  // FSM, round-robin pointer and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WR_PRIO;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (gnt_rd) rr_ptr <= (int'(sel) == NUM_OC-1) ? '0 : sel + 1'b1;
    end
  end

  // RF command register. Write data only moves on write grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en    <= 1'b0;
      rf_wr    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else begin
      rf_en <= gnt_rd || gnt_wr;
      if (gnt_wr) begin
        rf_wr    <= 1'b1;
        rf_addr  <= wb_row;
        rf_wdata <= wb_data;
      end else if (gnt_rd) begin
        rf_wr    <= 1'b0;
        rf_addr  <= sel_row;
      end
    end
  end

  // Read tag pipeline. It lines the collector ID up with the RF read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[RF_LAT-1:0], gnt_rd};
      tag_id <= {tag_id[RF_LAT-1:0], (gnt_rd ? sel : OCID_W'(0))};
    end
  end

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Testbench for rf_bank_arbiter. Directed scenarios plus randomised traffic.
// A behavioural model predicts the grants, the RF commands and the read
// returns. A small RF stub answers the DUT's read commands.
module tb_rf_bank_arbiter;

  localparam int NUM_OC     = 4;
  localparam int OCID_W     = 2;
  localparam int ROW_W      = 3;
  localparam int DATA_W     = 256;
  localparam int MAX_STARVE = 4;
  localparam int RF_LAT     = 1;
  localparam int NROWS      = 1 << ROW_W;
  localparam int CMD_W      = 1 + ROW_W + DATA_W;
  localparam int RD_W       = OCID_W + DATA_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_OC-1:0]       oc_req_valid = '0;
  logic [NUM_OC*ROW_W-1:0] oc_req_row = '0;
  logic [NUM_OC-1:0]       oc_req_ready;
  logic                    wb_valid = 1'b0;
  logic [ROW_W-1:0]        wb_row = '0;
  logic [DATA_W-1:0]       wb_data = '0;
  logic                    wb_ready;
  logic                    rf_en, rf_wr;
  logic [ROW_W-1:0]        rf_addr;
  logic [DATA_W-1:0]       rf_wdata;
  logic [DATA_W-1:0]       rf_rdata = '0;
  logic                    rd_valid;
  logic [OCID_W-1:0]       rd_ocid;
  logic [DATA_W-1:0]       rd_data;
  logic                    starve_force;

  rf_bank_arbiter #(
    .NUM_OC(NUM_OC), .OCID_W(OCID_W), .ROW_W(ROW_W), .DATA_W(DATA_W),
    .MAX_STARVE(MAX_STARVE), .RF_LAT(RF_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .oc_req_valid(oc_req_valid), .oc_req_row(oc_req_row), .oc_req_ready(oc_req_ready),
    .wb_valid(wb_valid), .wb_row(wb_row), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_en(rf_en), .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .rd_valid(rd_valid), .rd_ocid(rd_ocid), .rd_data(rd_data),
    .starve_force(starve_force)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NUM_OC*ROW_W-1:0] mk_rows(input int r0, input int r1, input int r2, input int r3);
    logic [NUM_OC*ROW_W-1:0] r;
    r = '0;
    r[0*ROW_W +: ROW_W] = ROW_W'(r0);
    r[1*ROW_W +: ROW_W] = ROW_W'(r1);
    r[2*ROW_W +: ROW_W] = ROW_W'(r2);
    r[3*ROW_W +: ROW_W] = ROW_W'(r3);
    return r;
  endfunction

  // ---------------- RF stub and its reference copy ----------------
  logic [DATA_W-1:0] rf_mem [NROWS];
  logic [DATA_W-1:0] m_mem  [NROWS];
  logic [DATA_W-1:0] dl     [RF_LAT];

  always @(posedge clk) begin
    #1;
    rf_rdata = dl[RF_LAT-1];
    for (int k = RF_LAT-1; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = '0;
    if (rf_en && !rst) begin
      if (rf_wr) rf_mem[rf_addr] = rf_wdata;
      else       dl[0] = rf_mem[rf_addr];
    end
  end

  task automatic reload_mem();
    for (int r = 0; r < NROWS; r++) begin
      logic [DATA_W-1:0] v;
      v = rand_data();
      rf_mem[r] = v;
      m_mem[r]  = v;
    end
    for (int k = 0; k < RF_LAT; k++) dl[k] = '0;
  endtask

  // ---------------- scoreboard queues ----------------
  logic [CMD_W-1:0] exp_q[$];
  int               exp_due[$];
  logic [RD_W-1:0]  rd_q[$];
  int               rd_due[$];

  // Model state, kept in plain integers.
  int                m_ptr = 0;
  int                m_wr_run = 0;
  bit                m_force = 0;
  logic [DATA_W-1:0] m_last_wd = '0;
  logic [NUM_OC-1:0] acc_oc = '0;
  bit                acc_wb = 0;

  // Reference model: predicts this cycle's grant and queues the expected results.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rf_en", rf_en, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_starve_force", starve_force, 0);
      chk("rst_oc_ready", oc_req_ready, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      m_ptr = 0; m_wr_run = 0; m_force = 0; m_last_wd = '0;
      acc_oc = '0; acc_wb = 0;
      exp_q.delete(); exp_due.delete(); rd_q.delete(); rd_due.delete();
    end else begin
      bit any, gr, gw, force_now;
      int s;
      logic [ROW_W-1:0] srow;
      any = (oc_req_valid != 0);
      s = 0;
      for (int k = NUM_OC-1; k >= 0; k--)
        if (oc_req_valid[(m_ptr + k) % NUM_OC]) s = (m_ptr + k) % NUM_OC;
      srow = oc_req_row[s*ROW_W +: ROW_W];
      gr = 0; gw = 0;
      force_now = m_force;
      if (m_force && any) begin
        m_wr_run = 0;
        if (wb_valid && srow == wb_row) gw = 1;
        else begin gr = 1; m_force = 0; end
      end else begin
        m_force = 0;
        if (wb_valid) gw = 1;
        else if (any) gr = 1;
        if (gw && any) begin
          m_wr_run++;
          if (m_wr_run == MAX_STARVE) begin m_force = 1; m_wr_run = 0; end
        end else begin
          m_wr_run = 0;
        end
      end
      chk("starve_force", starve_force, force_now);
      chk("oc_req_ready", oc_req_ready, gr ? (NUM_OC'(1) << s) : NUM_OC'(0));
      chk("wb_ready", wb_ready, gw);
      if (gw) begin
        m_last_wd = wb_data;
        exp_q.push_back({1'b1, wb_row, wb_data});
        exp_due.push_back(cyc + 1);
        m_mem[wb_row] = wb_data;
      end else if (gr) begin
        exp_q.push_back({1'b0, srow, m_last_wd});
        exp_due.push_back(cyc + 1);
        rd_q.push_back({OCID_W'(s), m_mem[srow]});
        rd_due.push_back(cyc + 1 + RF_LAT);
        m_ptr = (s + 1) % NUM_OC;
      end
      acc_oc = gr ? (NUM_OC'(1) << s) : NUM_OC'(0);
      acc_wb = gw;
    end
  end

  // Monitor: pops the expected entry when the DUT presents a command or a read return.
  always @(negedge clk) begin
    if (!rst) begin
      bit e_cmd, e_rd;
      logic [CMD_W-1:0] ce;
      logic [RD_W-1:0]  re;
      e_cmd = (exp_due.size() > 0) && (exp_due[0] == cyc);
      chk("rf_en", rf_en, e_cmd);
      if (e_cmd) begin
        ce = exp_q.pop_front();
        void'(exp_due.pop_front());
        if (rf_en) begin
          chk("rf_wr", rf_wr, ce[CMD_W-1]);
          chk("rf_addr", rf_addr, ce[DATA_W +: ROW_W]);
          chk("rf_wdata", rf_wdata, ce[DATA_W-1:0]);
        end
      end
      e_rd = (rd_due.size() > 0) && (rd_due[0] == cyc);
      chk("rd_valid", rd_valid, e_rd);
      if (e_rd) begin
        re = rd_q.pop_front();
        void'(rd_due.pop_front());
        if (rd_valid) begin
          chk("rd_ocid", rd_ocid, re[DATA_W +: OCID_W]);
          chk("rd_data", rd_data, re[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [NUM_OC-1:0] v, input logic [NUM_OC*ROW_W-1:0] rows,
                      input logic wv, input logic [ROW_W-1:0] wrow);
    @(posedge clk); #1;
    if (acc_wb || !wb_valid) wb_data = rand_data();
    oc_req_valid = v;
    oc_req_row   = rows;
    wb_valid     = wv;
    wb_row       = wrow;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0);
  endtask

  task automatic rand_phase(input int n, input int p_rd, input int p_wb, input int row_max);
    logic [NUM_OC-1:0]       v;
    logic [NUM_OC*ROW_W-1:0] rows;
    logic                    wv;
    logic [ROW_W-1:0]        wrow;
    for (int c = 0; c < n; c++) begin
      v = oc_req_valid; rows = oc_req_row; wv = wb_valid; wrow = wb_row;
      for (int i = 0; i < NUM_OC; i++) begin
        if (!v[i] || acc_oc[i]) begin
          v[i] = ($urandom_range(0, 99) < p_rd);
          rows[i*ROW_W +: ROW_W] = ROW_W'($urandom_range(0, row_max));
        end
      end
      if (!wv || acc_wb) begin
        wv   = ($urandom_range(0, 99) < p_wb);
        wrow = ROW_W'($urandom_range(0, row_max));
      end
      step(v, rows, wv, wrow);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    oc_req_valid = '0; wb_valid = 1'b0; oc_req_row = '0; wb_row = '0;
    #1;
    chk("rst_now_rf_en", rf_en, 0);
    chk("rst_now_rd_valid", rd_valid, 0);
    chk("rst_now_starve", starve_force, 0);
    reload_mem();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    reload_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin across all four collectors.
    for (int k = 0; k < 4; k++) step(4'b1111, mk_rows(1, 2, 3, 4), 1'b0, '0);
    idle(3);

    // Write wins against a pending read.
    step(4'b0100, mk_rows(0, 0, 6, 0), 1'b1, 3'd5);
    step(4'b0100, mk_rows(0, 0, 6, 0), 1'b0, '0);
    idle(3);

    // Starvation: writes held for ten cycles while OC2 waits.
    for (int k = 0; k < 10; k++) step(4'b0100, mk_rows(0, 0, 6, 0), 1'b1, 3'd1);
    idle(3);

    // Hazard: the forced read targets the row that is being written.
    for (int k = 0; k < 5; k++) step(4'b0010, mk_rows(0, 3, 0, 0), 1'b1, 3'd3);
    for (int k = 0; k < 3; k++) step(4'b0010, mk_rows(0, 3, 0, 0), 1'b1, 3'd5);
    idle(3);

    // Idle bus.
    idle(6);

    // Randomised traffic mixes.
    rand_phase(300, 40, 40, 7);
    rand_phase(300, 80, 95, 7);
    rand_phase(300, 70, 80, 1);
    rand_phase(200, 15, 15, 7);
    idle(6);

    // Reset in the middle of traffic with reads in flight.
    step(4'b1111, mk_rows(2, 3, 4, 5), 1'b0, '0);
    step(4'b1111, mk_rows(2, 3, 4, 5), 1'b0, '0);
    do_reset();
    idle(4);
    for (int k = 0; k < 2; k++) step(4'b1111, mk_rows(6, 7, 0, 1), 1'b0, '0);
    idle(8);

    chk("queues_drained", exp_q.size() + rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
